uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Buffered, parametrised asynchronous serial transmitter for the UART subsystem, the successor to the fixed 8-data/2-stop transmitter. It accepts characters over a valid/ready handshake into an internal FIFO and serialises them back-to-back on `txd`. Data width, stop-bit count and FIFO depth are configurable, and parity is an optional compile-time feature. Bit timing comes from an internal fractional baud accumulator, so the block needs no external tick source.

## Interface
- `CLK_FREQ`, 25000000: clock frequency in Hz.
- `BAUD`, 115200: line rate in bit/s.
- `DATA_BITS`, 8: data bits per frame, legal range 5..8.
- `STOP_BITS`, 1: stop bits per frame, 1 or 2.
- `FIFO_DEPTH`, 16: FIFO entries; must be a power of two, at least 2.
- `PARITY`, 0: 0 none, 1 odd, 2 even. Honoured only with `UART_TX_PARITY_EN`.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset: asynchronous, active-high.
- `tx_valid`  in  1  write request.
- `tx_data`  in  DATA_BITS  character to send; sampled on accept.
- `tx_ready`  out  1  FIFO can accept a write.
- `txd`  out  1  serial line, idle high, registered.
- `busy`  out  1  a frame is in progress or the FIFO is non-empty.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  number of FIFO entries.

## Operation
- **Reset:** clears FIFO pointers and state (state = IDLE). Outputs take these values:
  - `txd` = 1, `tx_ready` = 1, `busy` = 0, `fifo_level` = 0.
  - Baud accumulator = 0, bit counter = 0.
  - An in-flight frame is abandoned. `txd` returns high asynchronously.
- **Write accept:** a write is accepted when `tx_valid & tx_ready` is true at a clock edge.
  - `tx_ready` = !full, computed from registered state only.
  - If a pop occurs in the same cycle while the FIFO is full, the write is still refused.
- **Simultaneous push and pop:** `fifo_level` is unchanged and both pointers advance.
- **Baud generator:**
  - Accumulator width ACC_W = 16. Increment INC = round(BAUD·2^16 / CLK_FREQ), computed at elaboration.
  - A tick is the carry out of `acc + INC`.
  - The accumulator is held at 0 in IDLE and runs only in the other states.
- **State machine:** IDLE → START → DATA → [PARITY] → STOP → (IDLE or START).
  - IDLE: if the FIFO is non-empty, pop the head into the shift register and go to START. Otherwise `txd` = 1.
  - START: `txd` = 0; advance on tick.
  - DATA: `txd` = shift[0], LSB first. On each tick, shift right and increment the bit counter. After DATA_BITS ticks go to PARITY if it is enabled and `PARITY` ≠ 0; otherwise go to STOP.
  - PARITY: `txd` = parity bit. Even mode: XOR of the data bits. Odd mode: its complement. Advance on tick.
  - STOP: `txd` = 1 for STOP_BITS ticks. On the final tick:
    - If the FIFO is non-empty, pop and go directly to START. There is no idle gap, and the accumulator is not cleared.
    - Otherwise go to IDLE.
- **Parity source:** the parity value is computed from the popped character at load time and stored.
- **Widths:** `tx_data` is exactly DATA_BITS wide and there is no padding. The bit counter width is $clog2(DATA_BITS+1).

## Timing
- Accept to `txd` falling (FIFO empty, IDLE): 2 clocks.
  - Edge 1: write.
  - Edge 2: pop and state = START.
  - `txd` registers low on edge 2's output.
- Each line bit lasts one tick period (≈ CLK_FREQ/BAUD clocks; exact when the division is exact).
- Frame length: 1 + DATA_BITS + P + STOP_BITS bit periods, where P = 1 if parity is active, else 0.
- `busy` deasserts on the edge that returns the FSM to IDLE with the FIFO empty.
- `fifo_level` is registered and updates on the accept/pop edge.

## Configuration
- `UART_TX_PARITY_EN` defined: the PARITY state, parity register and `PARITY` parameter are compiled in.
- `UART_TX_PARITY_EN` undefined: no parity logic exists, `PARITY` is ignored, and frames are always start + data + stop.

## Test plan
Bench parameters: CLK_FREQ = 16, BAUD = 1, giving INC = 4096, a tick every 16 clocks and an exact bit period of 16. FIFO_DEPTH = 4 unless stated.

- **Reset values:** assert `rst` → `txd` = 1, `tx_ready` = 1, `busy` = 0, `fifo_level` = 0.
- **Single 8N1 byte:** write 0x55 → after 2 clocks `txd` = 0 for 16 clocks, then 1,0,1,0,1,0,1,0 at 16 clocks each, then stop high for 16 clocks. `busy` falls 160 clocks after the start bit begins.
- **Back-to-back / FIFO full:** write 0xA1, 0xB2, 0xC3, 0xD4, 0xE5 on consecutive cycles.
  - First byte popped; `fifo_level` reaches 4; `tx_ready` = 0.
  - A sixth write held with `tx_valid` high is not accepted until the first frame ends.
  - All five frames are contiguous, with no high gap beyond the stop bits.
- **Parity** (`UART_TX_PARITY_EN`, 8E1): 0x07 → parity bit 1. With `PARITY` = 1 (odd), 0x07 → parity bit 0. Frame length is 176 clocks.
- **5N2:** DATA_BITS = 5, STOP_BITS = 2, write 0x13 → bits 1,1,0,0,1, then 32 clocks high; frame length 128 clocks.
- **Reset mid-frame:** assert `rst` during data bit 3 with 2 bytes queued → `txd` = 1 immediately, `fifo_level` = 0, and no further frames after release.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter with an internal fractional baud accumulator.
// Define UART_TX_PARITY_EN to compile in the parity bit (selected by PARITY).
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 25000000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16,
    parameter int PARITY     = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        tx_valid,
    input  logic [DATA_BITS-1:0]        tx_data,
    output logic                        tx_ready,
    output logic                        txd,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
    localparam int ACC_W = 16;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = $clog2(DATA_BITS + 1);
    // Rounded BAUD * 2^ACC_W / CLK_FREQ, widened so the product cannot overflow.
    localparam logic [63:0]      INC_WIDE = ((64'(BAUD) << ACC_W) + 64'(CLK_FREQ / 2)) / 64'(CLK_FREQ);
    localparam logic [ACC_W-1:0] INC      = INC_WIDE[ACC_W-1:0];

    if ((DATA_BITS < 5) || (DATA_BITS > 8)) begin : g_bad_data_bits
        $error("uart_tx_fifo: DATA_BITS must be 5..8");
    end
    if ((STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_bad_stop_bits
        $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
    end
    if ((PARITY < 0) || (PARITY > 2)) begin : g_bad_parity
        $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
    end

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
`ifdef UART_TX_PARITY_EN
        ST_PAR   = 3'd3,
`endif
        ST_STOP  = 3'd4
    } state_t;

`ifdef UART_TX_PARITY_EN
    localparam bit PAR_ON  = (PARITY != 0);
    localparam bit PAR_ODD = (PARITY == 1);

    function automatic logic parity_bit(input logic [DATA_BITS-1:0] d, input logic odd);
        parity_bit = (^d) ^ odd;
    endfunction

    logic par_r;
`endif

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_r;
    logic [PTR_W-1:0]     rd_ptr_r;
    logic [LVL_W-1:0]     level_r;
    logic [LVL_W-1:0]     level_s;
    logic                 tx_ready_r;
    logic                 busy_r;
    logic                 txd_r;
    logic                 txd_s;
    state_t               state_r;
    state_t               state_s;
    logic [ACC_W-1:0]     acc_r;
    logic [ACC_W-1:0]     acc_s;
    logic [ACC_W:0]       acc_sum_s;
    logic                 tick_s;
    logic [CNT_W-1:0]     bit_cnt_r;
    logic [CNT_W-1:0]     bit_cnt_s;
    logic [DATA_BITS-1:0] shift_r;
    logic [DATA_BITS-1:0] shift_s;
    logic [DATA_BITS-1:0] head_s;
    logic                 empty_s;
    logic                 push_s;
    logic                 pop_s;

    assign head_s  = mem[rd_ptr_r];
    assign empty_s = (level_r == '0);
    // tx_ready_r mirrors !full of the registered level, so a same-cycle pop never admits a write.
    assign push_s  = tx_valid & tx_ready_r;

    // Next-state, baud tick, shift register and line value.
    always_comb begin
        state_s   = state_r;
        bit_cnt_s = bit_cnt_r;
        shift_s   = shift_r;
        pop_s     = 1'b0;
        txd_s     = 1'b1;
        acc_sum_s = {1'b0, acc_r} + {1'b0, INC};
        if (state_r == ST_IDLE) begin
            tick_s = 1'b0;
            acc_s  = '0;
        end else begin
            tick_s = acc_sum_s[ACC_W];
            acc_s  = acc_sum_s[ACC_W-1:0];
        end
        case (state_r)
            ST_IDLE: begin
                if (!empty_s) begin
                    pop_s   = 1'b1;
                    shift_s = head_s;
                    state_s = ST_START;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (tick_s) begin
                    state_s = ST_DATA;
                end else begin
                    state_s = ST_START;
                end
            end
            ST_DATA: begin
                if (tick_s) begin
                    shift_s = {1'b0, shift_r[DATA_BITS-1:1]};
                    if (bit_cnt_r == CNT_W'(DATA_BITS - 1)) begin
                        bit_cnt_s = '0;
`ifdef UART_TX_PARITY_EN
                        state_s   = PAR_ON ? ST_PAR : ST_STOP;
`else
                        state_s   = ST_STOP;
`endif
                    end else begin
                        bit_cnt_s = bit_cnt_r + CNT_W'(1);
                    end
                end else begin
                    state_s = ST_DATA;
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PAR: begin
                if (tick_s) begin
                    state_s = ST_STOP;
                end else begin
                    state_s = ST_PAR;
                end
            end
`endif
            ST_STOP: begin
                if (tick_s) begin
                    if (bit_cnt_r == CNT_W'(STOP_BITS - 1)) begin
                        bit_cnt_s = '0;
                        // Chain straight into the next start bit to keep frames contiguous.
                        if (!empty_s) begin
                            pop_s   = 1'b1;
                            shift_s = head_s;
                            state_s = ST_START;
                        end else begin
                            state_s = ST_IDLE;
                        end
                    end else begin
                        bit_cnt_s = bit_cnt_r + CNT_W'(1);
                    end
                end else begin
                    state_s = ST_STOP;
                end
            end
            default: begin
                state_s   = ST_IDLE;
                bit_cnt_s = '0;
            end
        endcase
        case (state_s)
            ST_START: txd_s = 1'b0;
            ST_DATA:  txd_s = shift_s[0];
`ifdef UART_TX_PARITY_EN
            ST_PAR:   txd_s = par_r;
`endif
            default:  txd_s = 1'b1;
        endcase
    end

    // FIFO occupancy after this cycle's push and pop.
    always_comb begin
        level_s = level_r;
        if (push_s && !pop_s) begin
            level_s = level_r + LVL_W'(1);
        end else if (pop_s && !push_s) begin
            level_s = level_r - LVL_W'(1);
        end else begin
            level_s = level_r;
        end
    end

    // FIFO storage; contents need no reset because the level gates every read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem[wr_ptr_r] <= tx_data;
        end
    end

    // Control state, pointers and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            acc_r      <= '0;
            bit_cnt_r  <= '0;
            shift_r    <= '0;
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            level_r    <= '0;
            tx_ready_r <= 1'b1;
            busy_r     <= 1'b0;
            txd_r      <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_r      <= 1'b0;
`endif
        end else begin
            state_r    <= state_s;
            acc_r      <= acc_s;
            bit_cnt_r  <= bit_cnt_s;
            shift_r    <= shift_s;
            level_r    <= level_s;
            tx_ready_r <= (level_s != LVL_W'(FIFO_DEPTH));
            busy_r     <= (state_s != ST_IDLE) || (level_s != '0);
            txd_r      <= txd_s;
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
`ifdef UART_TX_PARITY_EN
                par_r    <= parity_bit(head_s, PAR_ODD);
`endif
            end
        end
    end

    assign tx_ready   = tx_ready_r;
    assign txd        = txd_r;
    assign busy       = busy_r;
    assign fifo_level = level_r;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed writes queue expected frames; a monitor decodes txd
// and checks each frame. Parity instances are added when UART_TX_PARITY_EN is defined.
module tb_uart_tx_fifo;
    typedef struct {
        logic [7:0] data;
        int         par;    // expected parity bit, -1 when the frame carries none
        int         start;  // expected start-bit cycle, -1 when not checked
        bit         abort;  // frame cut by reset: consume without checking
    } exp_t;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    int         sel      = 0;
    int         cyc      = 0;
    int         n_cmp    = 0;
    int         n_fail   = 0;
    int         frames   = 0;
    int         m_db     = 8;
    int         m_sb     = 1;
    bit         m_par    = 1'b0;
    exp_t       q[$];
    logic [7:0] burst [5] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic txd0, rdy0, busy0, txd1, rdy1, busy1;
    logic [2:0] lvl0, lvl1;

    uart_tx_fifo #(.CLK_FREQ(16), .BAUD(1), .DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(4), .PARITY(0)) u0 (
        .clk(clk), .rst(rst), .tx_valid(tx_valid && (sel == 0)), .tx_data(tx_data),
        .tx_ready(rdy0), .txd(txd0), .busy(busy0), .fifo_level(lvl0));

    uart_tx_fifo #(.CLK_FREQ(16), .BAUD(1), .DATA_BITS(5), .STOP_BITS(2), .FIFO_DEPTH(4), .PARITY(0)) u1 (
        .clk(clk), .rst(rst), .tx_valid(tx_valid && (sel == 1)), .tx_data(tx_data[4:0]),
        .tx_ready(rdy1), .txd(txd1), .busy(busy1), .fifo_level(lvl1));

`ifdef UART_TX_PARITY_EN
    logic txd2, rdy2, busy2, txd3, rdy3, busy3;
    logic [2:0] lvl2, lvl3;

    uart_tx_fifo #(.CLK_FREQ(16), .BAUD(1), .DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(4), .PARITY(2)) u2 (
        .clk(clk), .rst(rst), .tx_valid(tx_valid && (sel == 2)), .tx_data(tx_data),
        .tx_ready(rdy2), .txd(txd2), .busy(busy2), .fifo_level(lvl2));

    uart_tx_fifo #(.CLK_FREQ(16), .BAUD(1), .DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(4), .PARITY(1)) u3 (
        .clk(clk), .rst(rst), .tx_valid(tx_valid && (sel == 3)), .tx_data(tx_data),
        .tx_ready(rdy3), .txd(txd3), .busy(busy3), .fifo_level(lvl3));
`endif

    logic txd_m, rdy_m, busy_m;
    logic [2:0] lvl_m;

    always_comb begin
        txd_m  = txd0;
        rdy_m  = rdy0;
        busy_m = busy0;
        lvl_m  = lvl0;
        case (sel)
            1: begin txd_m = txd1; rdy_m = rdy1; busy_m = busy1; lvl_m = lvl1; end
`ifdef UART_TX_PARITY_EN
            2: begin txd_m = txd2; rdy_m = rdy2; busy_m = busy2; lvl_m = lvl2; end
            3: begin txd_m = txd3; rdy_m = rdy3; busy_m = busy3; lvl_m = lvl3; end
`endif
            default: begin end
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_frame(input logic [7:0] d, input int par, input int start, input bit abort);
        exp_t e;
        e.data  = d;
        e.par   = par;
        e.start = start;
        e.abort = abort;
        q.push_back(e);
    endtask

    task automatic wait_idle(input int limit, output int t);
        t = -1;
        for (int k = 0; k < limit; k++) begin
            @(negedge clk);
            if (busy_m === 1'b0) begin
                t = cyc;
                break;
            end
        end
    endtask

    // Monitor: decode each frame at mid-bit and compare with the head of the queue.
    initial begin : monitor
        exp_t       e;
        logic [7:0] got;
        logic       start_bit, par_bit, stops_high;
        int         t0;
        forever begin
            @(negedge clk);
            if ((txd_m === 1'b0) && (rst === 1'b0)) begin
                t0 = cyc;
                frames++;
                got = 8'h00;
                par_bit = 1'b0;
                stops_high = 1'b1;
                repeat (8) @(negedge clk);
                start_bit = txd_m;
                for (int i = 0; i < m_db; i++) begin
                    repeat (16) @(negedge clk);
                    got[i] = txd_m;
                end
                if (m_par) begin
                    repeat (16) @(negedge clk);
                    par_bit = txd_m;
                end
                for (int s = 0; s < m_sb; s++) begin
                    repeat (16) @(negedge clk);
                    if (txd_m !== 1'b1) stops_high = 1'b0;
                end
                repeat (7) @(negedge clk);
                if (q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected frame: got data 0x%0h at cycle %0d, expected no frame", got, t0);
                end else begin
                    e = q.pop_front();
                    if (!e.abort) begin
                        check("frame data", 32'(got), 32'(e.data));
                        check("start bit", 32'(start_bit), 32'd0);
                        check("stop bits", 32'(stops_high), 32'd1);
                        if (e.start >= 0) check("frame start cycle", t0, e.start);
                        if (e.par >= 0) check("parity bit", 32'(par_bit), e.par);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: run exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int c0, t_end, acc, lows;
        repeat (3) @(negedge clk);
        check("reset txd", 32'(txd0), 32'd1);
        check("reset tx_ready", 32'(rdy0), 32'd1);
        check("reset busy", 32'(busy0), 32'd0);
        check("reset fifo_level", 32'(lvl0), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single 8N1 byte.
        c0 = cyc;
        tx_data = 8'h55;
        tx_valid = 1'b1;
        expect_frame(8'h55, -1, c0 + 2, 1'b0);
        @(negedge clk);
        tx_valid = 1'b0;
        check("level after accept", 32'(lvl_m), 32'd1);
        check("txd before pop", 32'(txd_m), 32'd1);
        @(negedge clk);
        check("level after pop", 32'(lvl_m), 32'd0);
        check("busy in frame", 32'(busy_m), 32'd1);
        wait_idle(400, t_end);
        check("8N1 busy fall", t_end, c0 + 162);

        // Burst of five, FIFO fills, sixth write held off.
        repeat (2) @(negedge clk);
        c0 = cyc;
        for (int k = 0; k < 5; k++) begin
            tx_data = burst[k];
            tx_valid = 1'b1;
            expect_frame(burst[k], -1, c0 + 2 + 160 * k, 1'b0);
            @(negedge clk);
        end
        check("full level", 32'(lvl_m), 32'd4);
        check("full tx_ready", 32'(rdy_m), 32'd0);
        tx_data = 8'hF6;
        expect_frame(8'hF6, -1, c0 + 2 + 800, 1'b0);
        acc = -1;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (rdy_m === 1'b1) begin
                acc = cyc + 1;
                break;
            end
        end
        @(negedge clk);
        tx_valid = 1'b0;
        check("held write accept cycle", acc, c0 + 163);
        check("level after held write", 32'(lvl_m), 32'd4);
        wait_idle(2000, t_end);
        check("burst busy fall", t_end, c0 + 962);

`ifdef UART_TX_PARITY_EN
        // 8E1 then 8O1 with 0x07 (three ones).
        m_par = 1'b1;
        for (int p = 0; p < 2; p++) begin
            sel = 2 + p;
            repeat (2) @(negedge clk);
            c0 = cyc;
            tx_data = 8'h07;
            tx_valid = 1'b1;
            expect_frame(8'h07, (p == 0) ? 1 : 0, c0 + 2, 1'b0);
            @(negedge clk);
            tx_valid = 1'b0;
            wait_idle(400, t_end);
            check("parity frame length", t_end, c0 + 178);
        end
        m_par = 1'b0;
`endif

        // 5N2 instance.
        sel = 1;
        m_db = 5;
        m_sb = 2;
        repeat (2) @(negedge clk);
        c0 = cyc;
        tx_data = 8'h13;
        tx_valid = 1'b1;
        expect_frame(8'h13, -1, c0 + 2, 1'b0);
        @(negedge clk);
        tx_valid = 1'b0;
        wait_idle(400, t_end);
        check("5N2 frame length", t_end, c0 + 130);

        // Reset during data bit 3 of 0xF0 with two bytes queued.
        sel = 0;
        m_db = 8;
        m_sb = 1;
        repeat (2) @(negedge clk);
        c0 = cyc;
        tx_data = 8'hF0;
        tx_valid = 1'b1;
        expect_frame(8'hF0, -1, -1, 1'b1);
        @(negedge clk);
        tx_data = 8'h11;
        @(negedge clk);
        tx_data = 8'h22;
        @(negedge clk);
        tx_valid = 1'b0;
        check("queued before reset", 32'(lvl_m), 32'd2);
        repeat (71) @(negedge clk);
        check("data bit 3 low", 32'(txd_m), 32'd0);
        rst = 1'b1;
        #1;
        check("txd async on reset", 32'(txd_m), 32'd1);
        check("level on reset", 32'(lvl_m), 32'd0);
        check("busy on reset", 32'(busy_m), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        lows = 0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (txd_m !== 1'b1) lows++;
        end
        check("line idle after reset", lows, 0);
        check("level after reset", 32'(lvl_m), 32'd0);
        check("busy after reset", 32'(busy_m), 32'd0);
        check("expected frames left", q.size(), 0);
`ifdef UART_TX_PARITY_EN
        check("frame count", frames, 11);
`else
        check("frame count", frames, 9);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
